// File: rtl/data_memory_responder_if.sv
// Memory-stage request/response bus between the pipeline and the data memory.
//   req_valid/req_write/req_addr/req_wdata : request from the memory stage
//   req_ready                              : responder idle and able to accept
//   resp_valid/resp_rdata/resp_err         : one-cycle response strobe and payload
//   sel_stall                              : stall request back to the memory stage
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        sel_stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, sel_stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, sel_stall
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory for the memory stage of the pipeline.
// Accepts one load/store in IDLE, waits LATENCY cycles, then issues a
// one-cycle response. Stores commit on the edge entering RESP.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears state and all storage
//   bus   : slave side of data_memory_responder_if
module data_memory_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    logic                fault_c;
    logic                mem_we_c;
    logic [IDX_W-1:0]    idx_c;

    // Fault on misalignment or a word index beyond the array
    assign fault_c = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign idx_c   = addr_q[IDX_W+1:2];

    // State and latched request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    // Next state, counter and response payload
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter hits zero on this edge: commit and present the response
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d        = '0;
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = fault_c;
                    mem_we_c     = wr_q && !fault_c;
                    if (!wr_q && !fault_c) begin
                        resp_rdata_d = mem[idx_c];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    // Stall is combinational so the stage holds from the very cycle it requests
    assign bus.sel_stall  = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=15 instances for response timing.
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    data_memory_responder_if bus   ();
    data_memory_responder_if bus1  ();
    data_memory_responder_if bus15 ();

    data_memory_responder #(.LATENCY(2), .DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    data_memory_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    data_memory_responder #(.LATENCY(15), .DEPTH_WORDS(256)) dut_l15 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus15.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One transaction on the LATENCY=2 instance, response expected 3 cycles after accept
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        bit seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        #1;
        check({tag, "_ready_at_accept"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_stall_at_accept"}, 32'(bus.sel_stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k    = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            #1;
            if (bus.resp_valid) seen = 1'b1;
            else begin
                check({tag, "_stall_in_wait"}, 32'(bus.sel_stall), 32'd1);
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'd3);
        if (seen) begin
            check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
            check({tag, "_err"},   32'(bus.resp_err), 32'(exp_err));
            check({tag, "_stall_in_resp"}, 32'(bus.sel_stall), 32'd0);
            check({tag, "_ready_in_resp"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        #1;
        check({tag, "_valid_after"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_rdata_after"}, bus.resp_rdata, 32'd0);
        check({tag, "_err_after"},   32'(bus.resp_err), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int k;
        int t1;
        int t15;
        bit seen;
        bit saw_valid;

        bus.req_valid   = 1'b0; bus.req_write   = 1'b0; bus.req_addr   = '0; bus.req_wdata   = '0;
        bus1.req_valid  = 1'b0; bus1.req_write  = 1'b0; bus1.req_addr  = '0; bus1.req_wdata  = '0;
        bus15.req_valid = 1'b0; bus15.req_write = 1'b0; bus15.req_addr = '0; bus15.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready),  32'd1);
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata,      32'd0);
        check("rst_err",   32'(bus.resp_err),   32'd0);
        check("rst_stall", 32'(bus.sel_stall),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Basic store/load and a fresh word
        txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        txn("ld10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        txn("ld14", 1'b0, 32'h14, 32'd0, 32'd0, 1'b0);

        // Faults: misaligned and out of range, neither may write
        txn("ld12",  1'b0, 32'h12,  32'd0,        32'd0, 1'b1);
        txn("st400", 1'b1, 32'h400, 32'hCAFEF00D, 32'd0, 1'b1);
        txn("ld0",   1'b0, 32'h0,   32'd0,        32'd0, 1'b0);
        txn("st11",  1'b1, 32'h11,  32'h11111111, 32'd0, 1'b1);
        txn("ld10b", 1'b0, 32'h10,  32'd0, 32'hDEADBEEF, 1'b0);

        // Held req_valid with changing address: only the first is serviced
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.req_addr = 32'h14;
        k    = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            #1;
            if (bus.resp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("hold_first_latency", 32'(k), 32'd3);
        check("hold_first_rdata", bus.resp_rdata, 32'hDEADBEEF);
        check("hold_ready_in_resp", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("hold_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k    = 1;
        seen = 1'b0;
        while (k <= 40 && !seen) begin
            #1;
            if (bus.resp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("hold_second_latency", 32'(k), 32'd3);
        check("hold_second_rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);

        // Reset during WAIT abandons the store and clears storage
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.resp_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.resp_valid) saw_valid = 1'b1;
            if (i == 0) check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
            @(negedge clk);
        end
        check("rst_mid_no_resp", 32'(saw_valid), 32'd0);
        txn("ld20", 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
        txn("ld10_cleared", 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);

        // Latency extremes
        @(negedge clk);
        bus1.req_valid  = 1'b1; bus1.req_write  = 1'b1; bus1.req_addr  = 32'h4; bus1.req_wdata  = 32'hA5;
        bus15.req_valid = 1'b1; bus15.req_write = 1'b1; bus15.req_addr = 32'h4; bus15.req_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid  = 1'b0;
        bus15.req_valid = 1'b0;
        t1  = 0;
        t15 = 0;
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (bus1.resp_valid  && t1  == 0) t1  = i;
            if (bus15.resp_valid && t15 == 0) t15 = i;
            @(negedge clk);
        end
        check("lat1_resp_cycle",  32'(t1),  32'd2);
        check("lat15_resp_cycle", 32'(t15), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles between acceptance and response (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words (power of two).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning memory-stage request present.
REQ-006 SHALL have port req_write, input, 1, meaning 1 = store (STR), 0 = load (LDR).
REQ-007 SHALL have port req_addr, input, 32, meaning byte address from the ALU/pre-index path.
REQ-008 SHALL have port req_wdata, input, 32, meaning store data.
REQ-009 SHALL have port req_ready, output, 1, meaning responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid, output, 1, meaning one-cycle response strobe.
REQ-011 SHALL have port resp_rdata, output, 32, meaning load data, valid only with resp_valid.
REQ-012 SHALL have port resp_err, output, 1, meaning access fault, valid only with resp_valid.
REQ-013 SHALL have port sel_stall, output, 1, meaning pipeline stall request to the memory stage.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid=1 and req_ready=1, latching req_write, req_addr and req_wdata.
REQ-017 SHALL, on acceptance, load a wait counter with LATENCY and go to WAIT.
REQ-018 SHALL decrement the counter each WAIT cycle and go to RESP on the cycle the counter reaches 0.
REQ-019 SHALL leave RESP for IDLE after exactly one cycle.
REQ-020 SHALL therefore raise resp_valid exactly LATENCY+1 cycles after the accept edge (LATENCY=2: accept at T, response at T+3).
REQ-021 SHALL drive sel_stall combinationally = (IDLE and req_valid) or WAIT, and deassert it in RESP so the stage advances while capturing the response.
REQ-022 SHALL ignore req_valid in WAIT and RESP; the requester holds its request until req_ready.
REQ-023 SHALL flag a fault when latched addr[1:0] != 0 or the word index (addr[31:2]) >= DEPTH_WORDS.
REQ-024 SHALL, on a faulting request, suppress any write, drive resp_rdata=0 and resp_err=1 during RESP.
REQ-025 SHALL perform a non-faulting store into word addr[31:2] on the clock edge entering RESP, with resp_rdata=0 and resp_err=0.
REQ-026 SHALL, for a non-faulting load, drive resp_rdata with word addr[31:2] during RESP, and resp_err=0.
REQ-027 SHALL return the newly stored value to a load issued after a store to the same word completes (no stale data).
REQ-028 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.
REQ-029 SHALL allow back-to-back transactions with a minimum of one IDLE cycle between RESP and the next acceptance.

Reset
REQ-030 SHALL, on rst_n low at any time, enter IDLE immediately and hold: counter=0, resp_valid=0, resp_rdata=0, resp_err=0, latched request cleared.
REQ-031 SHALL clear all storage words to 0 during reset.
REQ-032 SHALL abandon an in-flight transaction on reset mid-WAIT or mid-RESP: no write performed, no response issued.
REQ-033 SHALL present req_ready=1 on the first cycle after rst_n rises; sel_stall then follows REQ-021.

Verification
REQ-034 Store addr 0x10, data 0xDEADBEEF, LATENCY=2 -> accept at T, sel_stall high T..T+2, resp_valid at T+3, resp_err=0, resp_rdata=0.
REQ-035 Load addr 0x10 after REQ-034 -> resp_rdata=0xDEADBEEF at T+3; load addr 0x14 -> resp_rdata=0.
REQ-036 Load addr 0x12 (misaligned) and store addr 0x400 (out of range, DEPTH_WORDS=256) -> resp_err=1, resp_rdata=0, later load 0x0 returns 0.
REQ-037 Hold req_valid continuously with changing addr during WAIT -> only the first request is serviced; next accepted one cycle after RESP.
REQ-038 Assert rst_n low during WAIT of store 0x20 data 0x12345678 -> no resp_valid, req_ready=1 after release, load 0x20 returns 0.
REQ-039 Run LATENCY=1 and LATENCY=15 builds -> resp_valid at T+2 and T+16 respectively.
